// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the switch debouncer slice.
package debounce_pkg;

   localparam int DEFAULT_TICK_DIVIDE    = 100000;
   localparam int DEFAULT_STABLE_SAMPLES = 10;

   // Bits needed to hold 0..n-1, never less than one so n = 1 still yields a legal vector.
   function automatic int count_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch-side bus of the debouncer: raw levels in, clean levels and strobes out.
// Edge strobes exist only when SWITCH_DEBOUNCER_EDGE_EN is defined.
interface switch_debouncer_if #(
   parameter int CHANNELS = 16
);

   logic [CHANNELS-1:0] switch_raw;
   logic [CHANNELS-1:0] switch_clean;
   logic                value_changed;
   logic                sample_tick;
`ifdef SWITCH_DEBOUNCER_EDGE_EN
   logic [CHANNELS-1:0] switch_rise;
   logic [CHANNELS-1:0] switch_fall;

   modport master (
      input  switch_raw,
      output switch_clean, value_changed, sample_tick, switch_rise, switch_fall
   );

   modport slave (
      output switch_raw,
      input  switch_clean, value_changed, sample_tick, switch_rise, switch_fall
   );
`else
   modport master (
      input  switch_raw,
      output switch_clean, value_changed, sample_tick
   );

   modport slave (
      output switch_raw,
      input  switch_clean, value_changed, sample_tick
   );
`endif

endinterface

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser, tick-driven stability counter and clean flop.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
   input  logic clock,
   input  logic reset_n,
   input  logic raw_bit,
   input  logic sample_tick,
   output logic clean_bit,
   output logic changed
);

   localparam int              CW     = count_width(STABLE_SAMPLES + 1);
   localparam logic [CW-1:0]   ACCEPT = CW'(STABLE_SAMPLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] count_q, count_d;
   logic          clean_q, clean_d;
   logic          changed_q, changed_d;

   always_comb begin
      sync1_d   = raw_bit;
      sync2_d   = sync1_q;
      count_d   = count_q;
      clean_d   = clean_q;
      changed_d = 1'b0;
      // Any agreeing tick restarts the count, so only an unbroken run of disagreement is accepted.
      if (sample_tick) begin
         if (sync2_q == clean_q) begin
            count_d = '0;
         end else if (count_q == ACCEPT) begin
            clean_d   = sync2_q;
            count_d   = '0;
            changed_d = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         count_q   <= '0;
         clean_q   <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         count_q   <= count_d;
         clean_q   <= clean_d;
         changed_q <= changed_d;
      end
   end

   assign clean_bit = clean_q;
   assign changed   = changed_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the board slide switches with a shared sample-tick prescaler.
// Define SWITCH_DEBOUNCER_EDGE_EN to add per-bit rise/fall strobes.
module switch_debouncer
   import debounce_pkg::*;
#(
   parameter int CHANNELS       = 16,
   parameter int TICK_DIVIDE    = DEFAULT_TICK_DIVIDE,
   parameter int STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
   input  logic                clock,
   input  logic                reset_n,
   switch_debouncer_if.master  bus
);

   localparam int            PW   = count_width(TICK_DIVIDE);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIVIDE - 1);

   logic [PW-1:0]       prescale_q, prescale_d;
   logic                tick_q, tick_d;
   logic                value_changed_q, value_changed_d;
   logic [CHANNELS-1:0] clean;
   logic [CHANNELS-1:0] changed;

   always_comb begin
      tick_d          = (prescale_q == LAST);
      prescale_d      = tick_d ? '0 : prescale_q + 1'b1;
      value_changed_d = |changed;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prescale_q      <= '0;
         tick_q          <= 1'b0;
         value_changed_q <= 1'b0;
      end else begin
         prescale_q      <= prescale_d;
         tick_q          <= tick_d;
         value_changed_q <= value_changed_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_channel #(
         .STABLE_SAMPLES (STABLE_SAMPLES)
      ) u_chan (
         .clock       (clock),
         .reset_n     (reset_n),
         .raw_bit     (bus.switch_raw[i]),
         .sample_tick (tick_q),
         .clean_bit   (clean[i]),
         .changed     (changed[i])
      );
   end

   assign bus.switch_clean  = clean;
   assign bus.value_changed = value_changed_q;
   assign bus.sample_tick   = tick_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
   logic [CHANNELS-1:0] rise_q, rise_d;
   logic [CHANNELS-1:0] fall_q, fall_d;

   // The channel strobe arrives while clean already shows the new level, so it gives the direction.
   always_comb begin
      rise_d = changed & clean;
      fall_d = changed & ~clean;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign bus.switch_rise = rise_q;
   assign bus.switch_fall = fall_q;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with TICK_DIVIDE=4, STABLE_SAMPLES=3.
`timescale 1ns/1ps
module tb_switch_debouncer;

   localparam int CH    = 16;
   localparam int TD    = 4;
   localparam int SS    = 3;
   // Raw change driven on a tick cycle (or reset release): channel samples land on every TD-th edge,
   // the SS-th disagreeing one updates clean, visible at the following negedge.
   localparam int LAT   = SS * TD + 1;
   localparam int BOUND = 200;

   typedef struct packed {
      logic [CH-1:0] clean;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   switch_debouncer_if #(.CHANNELS(CH)) bus ();

   switch_debouncer #(
      .CHANNELS       (CH),
      .TICK_DIVIDE    (TD),
      .STABLE_SAMPLES (SS)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int            n_checks  = 0;
   int            n_fail    = 0;
   exp_t          sb_q[$];
   logic [CH-1:0] exp_clean = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_change(input logic [CH-1:0] nv);
      exp_t e;
      e.clean = nv;
      e.rise  = nv & ~exp_clean;
      e.fall  = ~nv & exp_clean;
      sb_q.push_back(e);
      exp_clean = nv;
   endtask

   // Returns at a negedge where sample_tick is high.
   task automatic wait_tick();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.sample_tick && n < BOUND);
      check_eq("tick_seen", bus.sample_tick, 1'b1);
   endtask

   task automatic measure(input string tag, input logic [CH-1:0] old_v, input logic [CH-1:0] new_v);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (bus.switch_clean === old_v && n < BOUND);
      check_eq({tag, "_lat"}, n, LAT);
      check_eq({tag, "_val"}, bus.switch_clean, new_v);
      @(negedge clock);
      check_eq({tag, "_pulse"}, bus.value_changed, 1'b1);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (reset_n && bus.value_changed) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_changed", bus.value_changed, 1'b0);
         end else begin
            e = sb_q.pop_front();
            check_eq("sb_clean", bus.switch_clean, e.clean);
`ifdef SWITCH_DEBOUNCER_EDGE_EN
            check_eq("sb_rise", bus.switch_rise, e.rise);
            check_eq("sb_fall", bus.switch_fall, e.fall);
`endif
         end
      end
   end

   initial begin
      int n;
      bus.switch_raw = '1;
      reset_n        = 1'b0;
      repeat (6) begin
         @(negedge clock);
         check_eq("rst_clean", bus.switch_clean, '0);
         check_eq("rst_changed", bus.value_changed, 1'b0);
         check_eq("rst_tick", bus.sample_tick, 1'b0);
      end

      expect_change(16'hFFFF);
      reset_n = 1'b1;
      measure("release", 16'h0000, 16'hFFFF);

      wait_tick();
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.sample_tick && n < BOUND);
      check_eq("tick_period", n, TD);

      wait_tick();
      expect_change(16'h0000);
      bus.switch_raw = 16'h0000;
      measure("to_zero", 16'hFFFF, 16'h0000);

      // Bit 0 bounces 1,0,1,0 on successive ticks before settling high.
      wait_tick();
      for (int k = 0; k < 4; k++) begin
         bus.switch_raw[0] = (k % 2 == 0);
         wait_tick();
      end
      check_eq("bounce_hold", bus.switch_clean, 16'h0000);
      expect_change(16'h0001);
      bus.switch_raw[0] = 1'b1;
      measure("bounce", 16'h0000, 16'h0001);

      wait_tick();
      expect_change(16'h0000);
      bus.switch_raw = 16'h0000;
      measure("clear", 16'h0001, 16'h0000);

      wait_tick();
      expect_change(16'h00A5);
      bus.switch_raw = 16'h00A5;
      measure("step", 16'h0000, 16'h00A5);

      // Two-clock low glitch on bit 7 placed clear of the sampling edges.
      wait_tick();
      repeat (3) @(negedge clock);
      bus.switch_raw[7] = 1'b0;
      repeat (2) @(negedge clock);
      bus.switch_raw[7] = 1'b1;
      repeat (5 * TD) @(negedge clock);
      check_eq("glitch_clean", bus.switch_clean, 16'h00A5);

      wait_tick();
      expect_change(16'h80AD);
      bus.switch_raw = 16'h80AD;
      measure("simul", 16'h00A5, 16'h80AD);

      // Two disagreeing ticks, then reset before the third.
      wait_tick();
      bus.switch_raw = 16'hFFFF;
      repeat (3) wait_tick();
      check_eq("midcount_hold", bus.switch_clean, 16'h80AD);
      reset_n = 1'b0;
      #1;
      check_eq("midrst_clean", bus.switch_clean, '0);
      check_eq("midrst_changed", bus.value_changed, 1'b0);
      check_eq("midrst_tick", bus.sample_tick, 1'b0);
      exp_clean = '0;
      repeat (3) @(negedge clock);
      expect_change(16'hFFFF);
      reset_n = 1'b1;
      measure("rearm", 16'h0000, 16'hFFFF);

      repeat (4 * TD) @(negedge clock);
      check_eq("sb_drain", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
